// File: rtl/dispatch_queue.sv
// Buffered in-order dispatch stage between Rename and the reservation
// stations / ROB. Holds renamed groups in a small FIFO and each cycle sends
// out the oldest instructions in program order until one cannot get both an
// ROB slot and a channel on its reservation station.

package dispatch_queue_pkg;

    localparam int PIPE_WIDTH = 2;
    localparam int NUM_RS     = 4;

    localparam logic [1:0] RS_ALU = 2'd0;
    localparam logic [1:0] RS_LD  = 2'd1;
    localparam logic [1:0] RS_ST  = 2'd2;
    localparam logic [1:0] RS_MDU = 2'd3;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] FNC7_MULDIV   = 7'b0000001;

    typedef struct packed {
        logic        is_valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        has_rd;
        logic [31:0] imm;
    } instruction_t;

    typedef struct packed {
        logic        is_valid;
        logic        is_ready;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        has_rd;
        logic        exception;
        logic [6:0]  opcode;
        logic [31:0] result;
    } rob_entry_t;

endpackage

module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int DEPTH = 4,
    parameter int RS_CH = PIPE_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    output logic                                   enq_rdy,
    input  instruction_t [WIDTH-1:0]               enq_insts,
    input  logic [NUM_RS-1:0][RS_CH-1:0]           rs_rdys,
    output logic [NUM_RS-1:0][RS_CH-1:0]           rs_wes,
    output instruction_t [NUM_RS-1:0][RS_CH-1:0]   rs_issue_ports,
    input  logic [$clog2(WIDTH+1)-1:0]             rob_free,
    output logic [WIDTH-1:0]                       rob_we,
    output rob_entry_t [WIDTH-1:0]                 rob_entries,
    output logic [$clog2(DEPTH+1)-1:0]             occupancy,
    output logic [31:0]                            stall_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int CNT_W = $clog2(WIDTH+1);

    instruction_t       fifo_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [31:0]        stall_q, stall_d;

    logic               enqFire;
    logic [WIDTH-1:0]   enqWe;
    logic [PTR_W-1:0]   enqIdx [WIDTH];
    logic [CNT_W-1:0]   enqCount;
    logic [CNT_W-1:0]   deqCount;

    function automatic logic [1:0] decodeClass(input instruction_t inst);
        if (inst.opcode == OPC_LOAD)
            return RS_LD;
        else if (inst.opcode == OPC_STORE)
            return RS_ST;
        else if (inst.opcode == OPC_ARI_RTYPE && inst.funct7 == FNC7_MULDIV)
            return RS_MDU;
        else
            return RS_ALU;
    endfunction

    // Room for a whole group is judged on registered occupancy only.
    assign enq_rdy      = (DEPTH - int'(occ_q)) >= WIDTH;
    assign occupancy    = occ_q;
    assign stall_cycles = stall_q;
    assign enqFire      = enq_rdy && !flush && (|enqWe_raw());

    function automatic logic [WIDTH-1:0] enqWe_raw();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++)
            v[i] = enq_insts[i].is_valid;
        return v;
    endfunction

    // Compact valid slots onto consecutive tail positions.
    always_comb begin
        enqCount = '0;
        enqWe    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            enqIdx[i] = tail_q + PTR_W'(enqCount);
            enqWe[i]  = enqFire && enq_insts[i].is_valid;
            if (enqWe[i])
                enqCount = enqCount + CNT_W'(1);
        end
    end

    // In-order dispatch walk: stop at the first candidate lacking an ROB slot or RS channel.
    always_comb begin
        instruction_t     cand;
        logic [1:0]       cls;
        logic [CNT_W-1:0] chan;
        logic             chanRdy;
        logic             blocked;
        logic [CNT_W-1:0] classUsed [NUM_RS];

        rs_wes         = '0;
        rs_issue_ports = '0;
        rob_we         = '0;
        rob_entries    = '0;
        deqCount       = '0;
        cand           = '0;
        cls            = '0;
        chan           = '0;
        chanRdy        = 1'b0;
        blocked        = flush;
        for (int c = 0; c < NUM_RS; c++)
            classUsed[c] = '0;

        for (int k = 0; k < WIDTH; k++) begin
            cand    = fifo_q[head_q + PTR_W'(k)];
            cls     = decodeClass(cand);
            chan    = classUsed[cls];
            chanRdy = 1'b0;
            for (int j = 0; j < RS_CH; j++)
                if (j == int'(chan))
                    chanRdy = rs_rdys[cls][j];

            if (!blocked && k < int'(occ_q) && k < int'(rob_free) && chanRdy) begin
                for (int j = 0; j < RS_CH; j++) begin
                    if (j == int'(chan)) begin
                        rs_wes[cls][j]         = 1'b1;
                        rs_issue_ports[cls][j] = cand;
                    end
                end
                rob_we[k]                = 1'b1;
                rob_entries[k].is_valid  = 1'b1;
                rob_entries[k].is_ready  = 1'b0;
                rob_entries[k].pc        = cand.pc;
                rob_entries[k].rd        = cand.rd;
                rob_entries[k].has_rd    = cand.has_rd;
                rob_entries[k].exception = 1'b0;
                rob_entries[k].opcode    = cand.opcode;
                classUsed[cls]           = classUsed[cls] + CNT_W'(1);
                deqCount                 = deqCount + CNT_W'(1);
            end else begin
                blocked = 1'b1;
            end
        end
    end

    // Pointer, occupancy and stall-counter next state; flush empties the queue but keeps the counter.
    always_comb begin
        head_d  = head_q + PTR_W'(deqCount);
        tail_d  = tail_q + PTR_W'(enqCount);
        occ_d   = occ_q + OCC_W'(enqCount) - OCC_W'(deqCount);
        stall_d = stall_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else if (occ_q != '0 && deqCount == '0 && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Control state register; reset wins over flush and enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
        end
    end

    // Instruction storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++)
            if (enqWe[i])
                fifo_q[enqIdx[i]] <= enq_insts[i];
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue with the default 2-wide, 4-deep setup.
// Expected values are hand-derived; each check is an immediate assertion.

module tb_dispatch_queue;
   import dispatch_queue_pkg::*;

   logic                              clk = 1'b0;
   logic                              rst;
   logic                              flush;
   logic                              enq_rdy;
   instruction_t [1:0]                enq_insts;
   logic [NUM_RS-1:0][1:0]            rs_rdys;
   logic [NUM_RS-1:0][1:0]            rs_wes;
   instruction_t [NUM_RS-1:0][1:0]    rs_issue_ports;
   logic [1:0]                        rob_free;
   logic [1:0]                        rob_we;
   rob_entry_t [1:0]                  rob_entries;
   logic [2:0]                        occupancy;
   logic [31:0]                       stall_cycles;

   int compared   = 0;
   int mismatched = 0;

   dispatch_queue #(.WIDTH(2), .DEPTH(4), .RS_CH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .enq_rdy        (enq_rdy),
      .enq_insts      (enq_insts),
      .rs_rdys        (rs_rdys),
      .rs_wes         (rs_wes),
      .rs_issue_ports (rs_issue_ports),
      .rob_free       (rob_free),
      .rob_we         (rob_we),
      .rob_entries    (rob_entries),
      .occupancy      (occupancy),
      .stall_cycles   (stall_cycles)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // kind: 0 ALU-imm, 1 LD, 2 ST, 3 MDU, 4 ALU R-type (sub)
   function automatic instruction_t mkInst(input int kind, input logic [31:0] pc, input logic [4:0] rd);
      instruction_t inst;
      inst          = '0;
      inst.is_valid = 1'b1;
      inst.pc       = pc;
      inst.rd       = rd;
      inst.rs1      = 5'd1;
      inst.rs2      = 5'd2;
      inst.imm      = 32'h10;
      inst.has_rd   = (kind != 2);
      case (kind)
         1: inst.opcode = OPC_LOAD;
         2: inst.opcode = OPC_STORE;
         3: begin inst.opcode = OPC_ARI_RTYPE; inst.funct7 = FNC7_MULDIV; end
         4: begin inst.opcode = OPC_ARI_RTYPE; inst.funct7 = 7'b0100000; end
         default: inst.opcode = 7'b0010011;
      endcase
      return inst;
   endfunction

   function automatic rob_entry_t expRob(input instruction_t inst);
      rob_entry_t e;
      e          = '0;
      e.is_valid = 1'b1;
      e.pc       = inst.pc;
      e.rd       = inst.rd;
      e.has_rd   = inst.has_rd;
      e.opcode   = inst.opcode;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input instruction_t i0, input instruction_t i1);
      enq_insts[0] = i0;
      enq_insts[1] = i1;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      enq_insts = '0;
      flush     = 1'b0;
      #1;
   endtask

   initial begin
      instruction_t a, b, c, d;
      rst       = 1'b1;
      flush     = 1'b0;
      enq_insts = '0;
      rs_rdys   = '1;
      rob_free  = 2'd2;
      tick();
      tick();
      rst = 1'b0;
      #1;

      checkOutput("rstEnqRdy", 128'(enq_rdy), 128'(1'b1));
      checkOutput("rstOcc", 128'(occupancy), 128'(3'd0));
      checkOutput("rstRobWe", 128'(rob_we), 128'(2'b00));
      checkOutput("rstRsWes", 128'(rs_wes), 128'(8'h00));
      checkOutput("rstStall", 128'(stall_cycles), 128'(32'd0));

      // Two ALU ops go out together on ALU channels 0 and 1.
      a = mkInst(0, 32'h100, 5'd1);
      b = mkInst(4, 32'h104, 5'd2);
      applyStimulus(a, b);
      checkOutput("noBypassRobWe", 128'(rob_we), 128'(2'b00));
      tick();
      checkOutput("aluPairOcc", 128'(occupancy), 128'(3'd2));
      checkOutput("aluPairWes", 128'(rs_wes[0]), 128'(2'b11));
      checkOutput("aluPairPort0", 128'(rs_issue_ports[0][0]), 128'(a));
      checkOutput("aluPairPort1", 128'(rs_issue_ports[0][1]), 128'(b));
      checkOutput("aluPairRobWe", 128'(rob_we), 128'(2'b11));
      checkOutput("aluPairRob0", 128'(rob_entries[0]), 128'(expRob(a)));
      checkOutput("aluPairRob1", 128'(rob_entries[1]), 128'(expRob(b)));
      tick();
      checkOutput("aluPairDrained", 128'(occupancy), 128'(3'd0));

      // LD and MDU each land on channel 0 of their own station.
      a = mkInst(1, 32'h200, 5'd3);
      b = mkInst(3, 32'h204, 5'd4);
      applyStimulus(a, b);
      tick();
      checkOutput("ldMduLdWes", 128'(rs_wes[1]), 128'(2'b01));
      checkOutput("ldMduMduWes", 128'(rs_wes[3]), 128'(2'b01));
      checkOutput("ldMduAluWes", 128'(rs_wes[0]), 128'(2'b00));
      checkOutput("ldMduLdPort", 128'(rs_issue_ports[1][0]), 128'(a));
      checkOutput("ldMduMduPort", 128'(rs_issue_ports[3][0]), 128'(b));
      checkOutput("ldMduIdlePort", 128'(rs_issue_ports[3][1]), 128'(0));
      checkOutput("ldMduRobWe", 128'(rob_we), 128'(2'b11));
      tick();

      // Only one ALU channel free: partial dispatch, remainder next cycle.
      a = mkInst(0, 32'h300, 5'd5);
      b = mkInst(0, 32'h304, 5'd6);
      applyStimulus(a, b);
      tick();
      rs_rdys[0] = 2'b01;
      #1;
      checkOutput("partialWes", 128'(rs_wes[0]), 128'(2'b01));
      checkOutput("partialPort", 128'(rs_issue_ports[0][0]), 128'(a));
      checkOutput("partialRobWe", 128'(rob_we), 128'(2'b01));
      tick();
      checkOutput("partialOcc", 128'(occupancy), 128'(3'd1));
      checkOutput("restWes", 128'(rs_wes[0]), 128'(2'b01));
      checkOutput("restPort", 128'(rs_issue_ports[0][0]), 128'(b));
      checkOutput("restRobWe", 128'(rob_we), 128'(2'b01));
      checkOutput("restRob0", 128'(rob_entries[0]), 128'(expRob(b)));
      tick();
      checkOutput("restDrained", 128'(occupancy), 128'(3'd0));
      rs_rdys = '1;

      // Blocked store holds the ALU behind it; stall counter runs.
      a = mkInst(2, 32'h400, 5'd0);
      b = mkInst(0, 32'h404, 5'd7);
      applyStimulus(a, b);
      tick();
      rs_rdys[2] = 2'b00;
      #1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         checkOutput("stallRobWe", 128'(rob_we), 128'(2'b00));
         checkOutput("stallRsWes", 128'(rs_wes), 128'(8'h00));
         tick();
      end
      checkOutput("stallCount3", 128'(stall_cycles), 128'(32'd3));
      rs_rdys = '1;
      #1;
      checkOutput("releaseStWes", 128'(rs_wes[2]), 128'(2'b01));
      checkOutput("releaseAluWes", 128'(rs_wes[0]), 128'(2'b01));
      checkOutput("releaseStPort", 128'(rs_issue_ports[2][0]), 128'(a));
      checkOutput("releaseAluPort", 128'(rs_issue_ports[0][0]), 128'(b));
      checkOutput("releaseRobWe", 128'(rob_we), 128'(2'b11));
      tick();
      checkOutput("releaseStallHeld", 128'(stall_cycles), 128'(32'd3));

      // Slot 0 invalid: only slot 1 is written, leaving head=tail=1.
      c = mkInst(0, 32'h4F0, 5'd8);
      applyStimulus('0, c);
      tick();
      checkOutput("compactOcc", 128'(occupancy), 128'(3'd1));
      checkOutput("compactPort", 128'(rs_issue_ports[0][0]), 128'(c));
      checkOutput("compactRobWe", 128'(rob_we), 128'(2'b01));
      tick();

      // Fill to DEPTH with backend stalled; second group wraps index 3->0.
      rob_free = 2'd0;
      a = mkInst(0, 32'h500, 5'd9);
      b = mkInst(1, 32'h504, 5'd10);
      c = mkInst(3, 32'h508, 5'd11);
      d = mkInst(0, 32'h50C, 5'd12);
      applyStimulus(a, b);
      tick();
      checkOutput("fillOcc2", 128'(occupancy), 128'(3'd2));
      checkOutput("fillEnqRdy", 128'(enq_rdy), 128'(1'b1));
      checkOutput("fillRobWe", 128'(rob_we), 128'(2'b00));
      applyStimulus(c, d);
      tick();
      checkOutput("fullOcc", 128'(occupancy), 128'(3'd4));
      checkOutput("fullEnqRdy", 128'(enq_rdy), 128'(1'b0));
      checkOutput("fullStall", 128'(stall_cycles), 128'(32'd4));
      applyStimulus(mkInst(0, 32'h5F0, 5'd1), mkInst(0, 32'h5F4, 5'd2));
      tick();
      checkOutput("fullDropsEnq", 128'(occupancy), 128'(3'd4));
      rob_free = 2'd2;
      #1;
      checkOutput("drain1RobWe", 128'(rob_we), 128'(2'b11));
      checkOutput("drain1Alu", 128'(rs_issue_ports[0][0]), 128'(a));
      checkOutput("drain1Ld", 128'(rs_issue_ports[1][0]), 128'(b));
      tick();
      checkOutput("drain2Occ", 128'(occupancy), 128'(3'd2));
      checkOutput("drain2EnqRdy", 128'(enq_rdy), 128'(1'b1));
      checkOutput("drain2Mdu", 128'(rs_issue_ports[3][0]), 128'(c));
      checkOutput("drain2Alu", 128'(rs_issue_ports[0][0]), 128'(d));
      checkOutput("drain2Rob0", 128'(rob_entries[0]), 128'(expRob(c)));
      checkOutput("drain2Rob1", 128'(rob_entries[1]), 128'(expRob(d)));
      tick();
      checkOutput("drainedOcc", 128'(occupancy), 128'(3'd0));
      checkOutput("drainedStall", 128'(stall_cycles), 128'(32'd5));

      // Flush at occupancy 3 suppresses all writes and empties the queue.
      rob_free = 2'd0;
      applyStimulus(mkInst(0, 32'h600, 5'd1), mkInst(0, 32'h604, 5'd2));
      tick();
      applyStimulus('0, mkInst(1, 32'h608, 5'd3));
      tick();
      checkOutput("preFlushOcc", 128'(occupancy), 128'(3'd3));
      checkOutput("preFlushEnqRdy", 128'(enq_rdy), 128'(1'b0));
      rob_free = 2'd2;
      flush    = 1'b1;
      applyStimulus(mkInst(0, 32'h6F0, 5'd4), mkInst(0, 32'h6F4, 5'd5));
      checkOutput("flushRobWe", 128'(rob_we), 128'(2'b00));
      checkOutput("flushRsWes", 128'(rs_wes), 128'(8'h00));
      tick();
      checkOutput("postFlushOcc", 128'(occupancy), 128'(3'd0));
      checkOutput("postFlushEnqRdy", 128'(enq_rdy), 128'(1'b1));
      checkOutput("postFlushStall", 128'(stall_cycles), 128'(32'd6));
      checkOutput("postFlushRobWe", 128'(rob_we), 128'(2'b00));

      // Group offered during a flush with room available is still dropped.
      flush = 1'b1;
      applyStimulus(mkInst(0, 32'h700, 5'd6), mkInst(0, 32'h704, 5'd7));
      tick();
      checkOutput("flushEnqDropOcc", 128'(occupancy), 128'(3'd0));
      checkOutput("flushEnqDropRobWe", 128'(rob_we), 128'(2'b00));
      a = mkInst(0, 32'h800, 5'd8);
      applyStimulus(a, '0);
      tick();
      checkOutput("afterFlushPort", 128'(rs_issue_ports[0][0]), 128'(a));
      checkOutput("afterFlushRobWe", 128'(rob_we), 128'(2'b01));
      tick();

      // Reset mid-operation discards contents and clears the counter.
      rob_free = 2'd0;
      applyStimulus(mkInst(0, 32'h900, 5'd1), mkInst(0, 32'h904, 5'd2));
      tick();
      checkOutput("preResetOcc", 128'(occupancy), 128'(3'd2));
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      rob_free = 2'd2;
      #1;
      checkOutput("midResetOcc", 128'(occupancy), 128'(3'd0));
      checkOutput("midResetStall", 128'(stall_cycles), 128'(32'd0));
      checkOutput("midResetEnqRdy", 128'(enq_rdy), 128'(1'b1));
      checkOutput("midResetRobWe", 128'(rob_we), 128'(2'b00));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
